spi_master_param: RTL

//  Parametrised SPI master on the PCLK strobe bus (WR0..3 write, DR0..3 read), successor to spi_master5.

---
 rtl/spi_param_pkg.sv | 46 ++++
 rtl/spi_fifo.sv | 69 ++++++
 rtl/spi_master_param.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_param_pkg.sv
// Shared definitions for the parametrised SPI master.
//   - CONFIG (WR0), CMD (WR3) and STATUS (DR0) bit positions
//   - FSM state encoding
//   - clog2 helper for sizing pointers and counters
package spi_param_pkg;

  // CONFIG register fields
  localparam int unsigned CFG_CPHA   = 0;
  localparam int unsigned CFG_CPOL   = 1;
  localparam int unsigned CFG_LSB    = 2;
  localparam int unsigned CFG_EN     = 3;
  localparam int unsigned CFG_DIV_LO = 4;
  localparam int unsigned CFG_DIV_HI = 7;

  // CMD register fields
  localparam int unsigned CMD_IDX_LO = 0;
  localparam int unsigned CMD_IDX_HI = 3;
  localparam int unsigned CMD_HOLD   = 7;

  // STATUS word bit positions
  localparam int unsigned STS_BUSY     = 0;
  localparam int unsigned STS_TX_EMPTY = 1;
  localparam int unsigned STS_TX_FULL  = 2;
  localparam int unsigned STS_RX_EMPTY = 3;
  localparam int unsigned STS_RX_FULL  = 4;
  localparam int unsigned STS_RX_OVF   = 5;
  localparam int unsigned STS_TX_OVF   = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_LAST
  } spi_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO used for both the TX and RX queues of the SPI master.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, wdata_i   write request and data (ignored when full unless popping)
//   pop_i             read request (ignored when empty)
//   flush_i           empties the FIFO; wins over a same-cycle push/pop
//   rdata_o           head entry (valid when !empty_o)
//   full_o, empty_o   status
//   level_o           number of stored entries
module spi_fifo
  import spi_param_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW        = clog2(FIFO_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       level_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the slot
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master on the PCLK strobe bus.
// Ports:
//   PCLK, PRESET      clock, asynchronous active-high reset
//   WR0..WR3          CONFIG write, TX push, flush, CMD write
//   DR0..DR3          STATUS read (clears sticky flags), RX pop, TX level, RX level
//   PWDATA / PRDATA   bus write data / combinational read data
//   MOSI, MISO, SCK   serial interface
//   SS                active-low slave selects
module spi_master_param
  import spi_param_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_SS     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              WR0,
  input  logic              WR1,
  input  logic              WR2,
  input  logic              WR3,
  input  logic              DR0,
  input  logic              DR1,
  input  logic              DR2,
  input  logic              DR3,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SCK,
  output logic [NUM_SS-1:0] SS
);

  localparam int unsigned AW = clog2(FIFO_DEPTH);
  localparam int unsigned EW = clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  // Bus-visible registers
  logic [7:0] cfg_q;
  logic [3:0] cmd_idx_q;
  logic       cmd_hold_q;
  logic       tx_ovf_q, rx_ovf_q;

  // Per-frame latched settings
  logic       cpha_q, cpha_d, cpol_q, cpol_d, lsb_q, lsb_d, hold_q, hold_d;
  logic [3:0] div_q, div_d;

  // Datapath / FSM
  spi_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic              sck_q, sck_d, mosi_q, mosi_d;
  logic [NUM_SS-1:0] ss_q, ss_d;
  logic [DATA_W-1:0] txsh_q, txsh_d, rxsh_q, rxsh_d;

  // FIFO interface
  logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty, rx_drop;
  logic [DATA_W-1:0] tx_rdata, rx_rdata;
  logic [AW:0]       tx_level, rx_level;
  logic              tx_ovf_set, lead, sample;
  logic [6:0]        status;

  assign tx_flush   = WR2 && PWDATA[0];
  assign rx_flush   = WR2 && PWDATA[1];
  assign tx_push    = WR1 && !tx_full;
  assign tx_ovf_set = WR1 && tx_full && !tx_flush;
  assign rx_pop     = DR1;

  spi_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(PCLK), .rst_i(PRESET), .push_i(tx_push), .pop_i(tx_pop),
    .flush_i(tx_flush), .wdata_i(PWDATA), .rdata_o(tx_rdata),
    .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
  );

  spi_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(PCLK), .rst_i(PRESET), .push_i(rx_push), .pop_i(rx_pop),
    .flush_i(rx_flush), .wdata_i(rxsh_q), .rdata_o(rx_rdata),
    .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );

  function automatic logic out_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d, input logic lsb,
                                                 input logic b);
    return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
  endfunction

  assign lead   = ~edge_q[0];
  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
  assign sample = lead ^ cpha_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    txsh_d  = txsh_q;
    rxsh_d  = rxsh_q;
    cpha_d  = cpha_q;
    cpol_d  = cpol_q;
    lsb_d   = lsb_q;
    div_d   = div_q;
    hold_d  = hold_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    rx_drop = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        sck_d = cfg_q[CFG_CPOL];
        if (cfg_q[CFG_EN] && !tx_empty && !tx_flush) begin
          cpha_d  = cfg_q[CFG_CPHA];
          cpol_d  = cfg_q[CFG_CPOL];
          lsb_d   = cfg_q[CFG_LSB];
          div_d   = cfg_q[CFG_DIV_HI:CFG_DIV_LO];
          hold_d  = cmd_hold_q;
          tx_pop  = 1'b1;
          txsh_d  = tx_rdata;
          if (!cfg_q[CFG_CPHA]) begin
            mosi_d = out_bit(tx_rdata, cfg_q[CFG_LSB]);
            txsh_d = shift_out(tx_rdata, cfg_q[CFG_LSB]);
          end
          // Out-of-range index simply matches no select line
          for (int unsigned i = 0; i < NUM_SS; i++) begin
            ss_d[i] = (i != 32'(cmd_idx_q));
          end
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          edge_d  = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_SHIFT: begin
        if (cnt_q == div_q) begin
          cnt_d  = '0;
          sck_d  = ~sck_q;
          edge_d = edge_q + EW'(1);
          if (sample) begin
            rxsh_d = shift_in(rxsh_q, lsb_q, MISO);
          end else if (edge_q != LAST_EDGE) begin
            mosi_d = out_bit(txsh_q, lsb_q);
            txsh_d = shift_out(txsh_q, lsb_q);
          end
          if (edge_q == LAST_EDGE) begin
            sck_d   = cpol_q;
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_HOLD: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (rx_full) rx_drop = 1'b1;
          else         rx_push = 1'b1;
          // Back-to-back frame: skip SETUP, keep SS low, reuse latched mode
          if (hold_q && cfg_q[CFG_EN] && !tx_empty && !tx_flush) begin
            tx_pop = 1'b1;
            txsh_d = tx_rdata;
            if (!cpha_q) begin
              mosi_d = out_bit(tx_rdata, lsb_q);
              txsh_d = shift_out(tx_rdata, lsb_q);
            end
            edge_d  = '0;
            state_d = S_SHIFT;
          end else begin
            ss_d    = '1;
            state_d = S_LAST;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_LAST: begin
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= '1;
      txsh_q     <= '0;
      rxsh_q     <= '0;
      cpha_q     <= 1'b0;
      cpol_q     <= 1'b0;
      lsb_q      <= 1'b0;
      div_q      <= '0;
      hold_q     <= 1'b0;
      cfg_q      <= '0;
      cmd_idx_q  <= '0;
      cmd_hold_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      txsh_q  <= txsh_d;
      rxsh_q  <= rxsh_d;
      cpha_q  <= cpha_d;
      cpol_q  <= cpol_d;
      lsb_q   <= lsb_d;
      div_q   <= div_d;
      hold_q  <= hold_d;
      if (WR0) cfg_q <= PWDATA[7:0];
      if (WR3) begin
        cmd_idx_q  <= PWDATA[CMD_IDX_HI:CMD_IDX_LO];
        cmd_hold_q <= PWDATA[CMD_HOLD];
      end
      // A new overflow event outranks the read-to-clear
      if (tx_ovf_set) tx_ovf_q <= 1'b1;
      else if (DR0)   tx_ovf_q <= 1'b0;
      if (rx_drop)    rx_ovf_q <= 1'b1;
      else if (DR0)   rx_ovf_q <= 1'b0;
    end
  end

  always_comb begin
    status               = '0;
    status[STS_BUSY]     = (state_q != S_IDLE);
    status[STS_TX_EMPTY] = tx_empty;
    status[STS_TX_FULL]  = tx_full;
    status[STS_RX_EMPTY] = rx_empty;
    status[STS_RX_FULL]  = rx_full;
    status[STS_RX_OVF]   = rx_ovf_q;
    status[STS_TX_OVF]   = tx_ovf_q;
  end

  always_comb begin
    PRDATA = '0;
    if (DR0)      PRDATA = DATA_W'(status);
    else if (DR1) PRDATA = rx_empty ? '0 : rx_rdata;
    else if (DR2) PRDATA = DATA_W'(tx_level);
    else if (DR3) PRDATA = DATA_W'(rx_level);
  end

  assign SCK  = sck_q;
  assign MOSI = mosi_q;
  assign SS   = ss_q;

endmodule
